// File: rtl/binary_countup_divider_pkg.sv
// Shared definitions for the up-counting tone divider.
package binary_countup_divider_pkg;

  // Default bit width of the count and period values.
  localparam int DefaultWidth = 5;

  // IDLE waits for a first period; RUN counts and produces the tone.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/period_holding_reg.sv
// Holds one period value that arrives mid-period until the next wrap uses it.
module period_holding_reg #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic             i_consume,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_flag,
  output logic [WIDTH-1:0] o_value
);

  logic             r_flag;
  logic [WIDTH-1:0] r_value;

  // Capture a new value on load; drop the flag when the wrap consumes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flag  <= 1'b0;
      r_value <= '0;
    end else if (i_clear) begin
      r_flag  <= 1'b0;
      r_value <= '0;
    end else if (i_load) begin
      r_flag  <= 1'b1;
      r_value <= i_data;
    end else if (i_consume) begin
      r_flag  <= 1'b0;
    end
  end

  assign o_flag  = r_flag;
  assign o_value = r_value;

endmodule

// File: rtl/binary_countup_divider.sv
// Programmable up-counting tone divider: counts 0..P, pulses tc and toggles
// tone on every wrap. A period arriving while running waits for the next wrap.
module binary_countup_divider
  import binary_countup_divider_pkg::*;
#(
  parameter int WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] period_in,
  input  logic             period_valid,
  output logic             period_ready,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             tone,
  output logic             running
);

  state_e           r_state;
  state_e           w_stateNext;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_countNext;
  logic [WIDTH-1:0] r_period;
  logic [WIDTH-1:0] w_periodNext;
  logic             r_tc;
  logic             w_tcNext;
  logic             r_tone;
  logic             w_toneNext;

  logic             w_transfer;
  logic             w_wrap;
  logic             w_pendFlag;
  logic [WIDTH-1:0] w_pendValue;
  logic             w_pendLoad;
  logic             w_pendConsume;

  assign period_ready  = !w_pendFlag;
  assign w_transfer    = period_valid && period_ready && !clear;
  assign w_wrap        = (r_state == RUN) && enable && (r_count == r_period);
  assign w_pendLoad    = w_transfer && (r_state == RUN);
  assign w_pendConsume = w_wrap && w_pendFlag && !clear;

  period_holding_reg #(
    .WIDTH(WIDTH)
  ) u_pending (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (clear),
    .i_load   (w_pendLoad),
    .i_consume(w_pendConsume),
    .i_data   (period_in),
    .o_flag   (w_pendFlag),
    .o_value  (w_pendValue)
  );

  // Register all state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_period <= '0;
      r_tc     <= 1'b0;
      r_tone   <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_count  <= w_countNext;
      r_period <= w_periodNext;
      r_tc     <= w_tcNext;
      r_tone   <= w_toneNext;
    end
  end

  // Next-state logic; the wrap is a compare so full-scale periods never overflow.
  always_comb begin
    w_stateNext  = r_state;
    w_countNext  = r_count;
    w_periodNext = r_period;
    w_tcNext     = 1'b0;
    w_toneNext   = r_tone;
    if (clear) begin
      w_stateNext  = IDLE;
      w_countNext  = '0;
      w_periodNext = '0;
      w_toneNext   = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_countNext = '0;
          w_toneNext  = 1'b0;
          if (w_transfer) begin
            w_periodNext = period_in;
            w_stateNext  = RUN;
          end
        end
        RUN: begin
          if (w_wrap) begin
            w_countNext = '0;
            w_tcNext    = 1'b1;
            w_toneNext  = !r_tone;
            if (w_pendFlag) begin
              w_periodNext = w_pendValue;
            end
          end else if (enable) begin
            w_countNext = r_count + {{(WIDTH-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          w_stateNext = IDLE;
        end
      endcase
    end
  end

  assign count   = r_count;
  assign tc      = r_tc;
  assign tone    = r_tone;
  assign running = (r_state == RUN);

endmodule

// File: tb/tb_binary_countup_divider.sv
// Self-checking bench for binary_countup_divider: a period/queue model checked
// every cycle, plus hand-computed literal checkpoints along directed scenarios.
module tb_binary_countup_divider;

  localparam int W = 5;

  logic         clk;
  logic         reset;
  logic         clear;
  logic         enable;
  logic [W-1:0] period_in;
  logic         period_valid;
  logic         period_ready;
  logic [W-1:0] count;
  logic         tc;
  logic         tone;
  logic         running;

  int checks   = 0;
  int failures = 0;
  bit checkEn  = 0;

  // Model: running flag, count within period, tone phase, active and queued periods.
  bit mRun   = 0;
  int mCount = 0;
  bit mTc    = 0;
  bit mTone  = 0;
  int mP     = 0;
  int mPend[$];

  binary_countup_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .enable      (enable),
    .period_in   (period_in),
    .period_valid(period_valid),
    .period_ready(period_ready),
    .count       (count),
    .tc          (tc),
    .tone        (tone),
    .running     (running)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation and tally the result.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, then return just after the edge that samples them.
  task automatic applyStimulus(input logic en, input logic valid, input logic [W-1:0] pin,
                               input logic clr);
    enable       = en;
    period_valid = valid;
    period_in    = pin;
    clear        = clr;
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: a queue holds at most one future period, applied at a wrap.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mRun = 0; mCount = 0; mTc = 0; mTone = 0; mP = 0;
      mPend.delete();
    end else if (clear) begin
      mRun = 0; mCount = 0; mTc = 0; mTone = 0; mP = 0;
      mPend.delete();
    end else begin
      automatic bit xfer = period_valid && (mPend.size() == 0);
      mTc = 0;
      if (!mRun) begin
        if (xfer) begin
          mP   = int'(period_in);
          mRun = 1;
        end
      end else begin
        if (enable) begin
          if (mCount == mP) begin
            mCount = 0;
            mTc    = 1;
            mTone  = !mTone;
            if (mPend.size() > 0) mP = mPend.pop_front();
          end else begin
            mCount = mCount + 1;
          end
        end
        if (xfer) mPend.push_back(int'(period_in));
      end
    end
  end

  // Check every output against the model on each falling edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("cmp_count", int'(count), mCount);
      checkOutput("cmp_tc", int'(tc), int'(mTc));
      checkOutput("cmp_tone", int'(tone), int'(mTone));
      checkOutput("cmp_running", int'(running), int'(mRun));
      checkOutput("cmp_ready", int'(period_ready), (mPend.size() == 0) ? 1 : 0);
    end
  end

  initial begin
    reset        = 0;
    clear        = 0;
    enable       = 0;
    period_in    = '0;
    period_valid = 0;

    // Reset held for three clocks, then released.
    @(posedge clk);
    #1 checkEn = 1;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    checkOutput("rst_count", int'(count), 0);
    checkOutput("rst_tc", int'(tc), 0);
    checkOutput("rst_tone", int'(tone), 0);
    checkOutput("rst_running", int'(running), 0);
    checkOutput("rst_ready", int'(period_ready), 1);

    // P=3: count 0,1,2,3,0 with tc on wrap, tone period 8.
    applyStimulus(1, 1, 5'd3, 0);
    checkOutput("p3_load_running", int'(running), 1);
    checkOutput("p3_load_count", int'(count), 0);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1, 0, 5'd0, 0);
      checkOutput("p3_count", int'(count), i);
    end
    applyStimulus(1, 0, 5'd0, 0);
    checkOutput("p3_wrap_count", int'(count), 0);
    checkOutput("p3_wrap_tc", int'(tc), 1);
    checkOutput("p3_wrap_tone", int'(tone), 1);
    repeat (4) applyStimulus(1, 0, 5'd0, 0);
    checkOutput("p3_wrap2_tc", int'(tc), 1);
    checkOutput("p3_wrap2_tone", int'(tone), 0);

    // P=31: full sweep with a single wrap at the end.
    applyStimulus(0, 0, 5'd0, 1);
    checkOutput("clr_running", int'(running), 0);
    applyStimulus(1, 1, 5'd31, 0);
    repeat (31) applyStimulus(1, 0, 5'd0, 0);
    checkOutput("p31_top_count", int'(count), 31);
    checkOutput("p31_top_tc", int'(tc), 0);
    applyStimulus(1, 0, 5'd0, 0);
    checkOutput("p31_wrap_count", int'(count), 0);
    checkOutput("p31_wrap_tc", int'(tc), 1);
    checkOutput("p31_wrap_tone", int'(tone), 1);

    // P=0: every enabled cycle wraps; dropping enable holds tone and clears tc.
    applyStimulus(0, 0, 5'd0, 1);
    applyStimulus(1, 1, 5'd0, 0);
    checkOutput("p0_load_tc", int'(tc), 0);
    applyStimulus(1, 0, 5'd0, 0);
    checkOutput("p0_tc1", int'(tc), 1);
    checkOutput("p0_tone1", int'(tone), 1);
    applyStimulus(1, 0, 5'd0, 0);
    checkOutput("p0_tc2", int'(tc), 1);
    checkOutput("p0_tone2", int'(tone), 0);
    applyStimulus(1, 0, 5'd0, 0);
    checkOutput("p0_tone3", int'(tone), 1);
    applyStimulus(0, 0, 5'd0, 0);
    checkOutput("p0_hold_tc", int'(tc), 0);
    checkOutput("p0_hold_tone", int'(tone), 1);

    // P=5 with a new period of 2 arriving at count 2; it applies only at the wrap.
    applyStimulus(0, 0, 5'd0, 1);
    applyStimulus(1, 1, 5'd5, 0);
    applyStimulus(1, 0, 5'd0, 0);
    applyStimulus(1, 0, 5'd0, 0);
    checkOutput("pend_pre_count", int'(count), 2);
    applyStimulus(1, 1, 5'd2, 0);
    checkOutput("pend_count3", int'(count), 3);
    checkOutput("pend_ready0", int'(period_ready), 0);
    applyStimulus(1, 0, 5'd0, 0);
    applyStimulus(1, 0, 5'd0, 0);
    checkOutput("pend_count5", int'(count), 5);
    checkOutput("pend_ready_still0", int'(period_ready), 0);
    applyStimulus(1, 0, 5'd0, 0);
    checkOutput("pend_wrap_count", int'(count), 0);
    checkOutput("pend_wrap_ready", int'(period_ready), 1);
    applyStimulus(1, 0, 5'd0, 0);
    applyStimulus(1, 0, 5'd0, 0);
    checkOutput("newp_count2", int'(count), 2);
    applyStimulus(1, 0, 5'd0, 0);
    checkOutput("newp_wrap_count", int'(count), 0);
    checkOutput("newp_wrap_tc", int'(tc), 1);

    // Hold at count 4 with enable low, then clear beats a simultaneous period.
    applyStimulus(0, 0, 5'd0, 1);
    applyStimulus(1, 1, 5'd5, 0);
    repeat (4) applyStimulus(1, 0, 5'd0, 0);
    repeat (3) applyStimulus(0, 0, 5'd0, 0);
    checkOutput("hold_count", int'(count), 4);
    applyStimulus(1, 1, 5'd7, 1);
    checkOutput("clrx_running", int'(running), 0);
    checkOutput("clrx_count", int'(count), 0);
    checkOutput("clrx_tone", int'(tone), 0);
    applyStimulus(1, 0, 5'd0, 0);
    checkOutput("clrx_not_accepted", int'(running), 0);

    // Asynchronous reset mid-count takes effect between clock edges.
    applyStimulus(1, 1, 5'd5, 0);
    applyStimulus(1, 0, 5'd0, 0);
    applyStimulus(1, 0, 5'd0, 0);
    checkOutput("arst_pre_count", int'(count), 2);
    reset = 0;
    #1;
    checkOutput("arst_count", int'(count), 0);
    checkOutput("arst_running", int'(running), 0);
    checkOutput("arst_tc", int'(tc), 0);
    checkOutput("arst_ready", int'(period_ready), 1);
    #1 reset = 1;
    applyStimulus(0, 0, 5'd0, 0);
    checkOutput("arst_after_running", int'(running), 0);

    checkEn = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
